jamma_joy_scanner: RTL and testbench

//  Front end for the multiplexed JAMMA control harness. Drives the player-select line,

---
 rtl/jamma_joy_scanner_if.sv | 21 ++
 rtl/jamma_joy_scanner.sv | 134 +++++++++++++
 tb/tb_jamma_joy_scanner.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/jamma_joy_scanner_if.sv
// rtl/jamma_joy_scanner_if.sv - harness-side and core-side signals of the JAMMA joystick scanner
interface jamma_joy_scanner_if;
    logic [7:0] jjoy;
    logic [1:0] jcoin;
    logic [5:0] joystick;
    logic       jselect;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic [1:0] coin;
    logic       scan_tick;

    modport master (
        output jjoy, jcoin, joystick,
        input  jselect, joy1, joy2, coin, scan_tick
    );

    modport slave (
        input  jjoy, jcoin, joystick,
        output jselect, joy1, joy2, coin, scan_tick
    );
endinterface

// File: rtl/jamma_joy_scanner.sv
// rtl/jamma_joy_scanner.sv - multiplexed JAMMA P1/P2 bus scanner with per-bit and coin debounce
module jamma_joy_scanner #(
    parameter int SETTLE    = 4,
    parameter int DEB_COUNT = 3,
    parameter int DEB_W     = 2
) (
    input  logic                pclk,
    input  logic                reset,
    jamma_joy_scanner_if.slave  bus
);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_COUNT - 1);

    typedef enum logic [1:0] {S1_SET, S1_SMP, S2_SET, S2_SMP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            jselect_q, jselect_d;
    logic            scan_tick_q, scan_tick_d;
    logic            smp1, smp2;

    logic [7:0]       joy1_q, joy1_d, joy2_q, joy2_d;
    logic [1:0]       coin_q, coin_d;
    logic [1:0]       coin_s1_q, coin_s2_q;
    logic [DEB_W-1:0] cnt1_q [8];
    logic [DEB_W-1:0] cnt1_d [8];
    logic [DEB_W-1:0] cnt2_q [8];
    logic [DEB_W-1:0] cnt2_d [8];
    logic [DEB_W-1:0] cntc_q [2];
    logic [DEB_W-1:0] cntc_d [2];
    logic [7:0]       raw1;

    // Settle counter counts up from 0, so it sits at 0 both out of reset and on every SET entry.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        smp1     = 1'b0;
        smp2     = 1'b0;
        case (state_q)
            S1_SET: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = S1_SMP;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S1_SMP: begin
                smp1    = 1'b1;
                state_d = S2_SET;
            end
            S2_SET: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = S2_SMP;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S2_SMP: begin
                smp2    = 1'b1;
                state_d = S1_SET;
            end
            default: state_d = S1_SET;
        endcase
        jselect_d   = (state_d == S2_SET) || (state_d == S2_SMP);
        scan_tick_d = smp2;
    end

    function automatic logic [DEB_W:0] deb_step(input logic raw, input logic cur,
                                                input logic [DEB_W-1:0] cnt);
        if (raw == cur)
            return {cur, {DEB_W{1'b0}}};
        else if (cnt == DEB_LAST)
            return {raw, {DEB_W{1'b0}}};
        else
            return {cur, cnt + 1'b1};
    endfunction

    assign raw1 = bus.jjoy & {2'b11, bus.joystick};

    always_comb begin
        joy1_d = joy1_q;
        joy2_d = joy2_q;
        coin_d = coin_q;
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        cntc_d = cntc_q;
        for (int i = 0; i < 8; i++) begin
            if (smp1) {joy1_d[i], cnt1_d[i]} = deb_step(raw1[i], joy1_q[i], cnt1_q[i]);
            if (smp2) {joy2_d[i], cnt2_d[i]} = deb_step(bus.jjoy[i], joy2_q[i], cnt2_q[i]);
        end
        for (int i = 0; i < 2; i++) begin
            if (scan_tick_q) {coin_d[i], cntc_d[i]} = deb_step(coin_s2_q[i], coin_q[i], cntc_q[i]);
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= S1_SET;
            settle_q    <= '0;
            jselect_q   <= 1'b0;
            scan_tick_q <= 1'b0;
            joy1_q      <= 8'hFF;
            joy2_q      <= 8'hFF;
            coin_q      <= 2'b11;
            coin_s1_q   <= 2'b11;
            coin_s2_q   <= 2'b11;
            cnt1_q      <= '{default: '0};
            cnt2_q      <= '{default: '0};
            cntc_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            jselect_q   <= jselect_d;
            scan_tick_q <= scan_tick_d;
            joy1_q      <= joy1_d;
            joy2_q      <= joy2_d;
            coin_q      <= coin_d;
            coin_s1_q   <= bus.jcoin;
            coin_s2_q   <= coin_s1_q;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            cntc_q      <= cntc_d;
        end
    end

    assign bus.jselect   = jselect_q;
    assign bus.scan_tick = scan_tick_q;
    assign bus.joy1      = joy1_q;
    assign bus.joy2      = joy2_q;
    assign bus.coin      = coin_q;
endmodule

// File: tb/tb_jamma_joy_scanner.sv
// tb/tb_jamma_joy_scanner.sv - scoreboard bench for the JAMMA joystick scanner
module tb_jamma_joy_scanner;
    logic pclk = 1'b0;
    logic reset = 1'b1;
    always #5 pclk = ~pclk;

    jamma_joy_scanner_if jif();

    jamma_joy_scanner #(.SETTLE(4), .DEB_COUNT(3), .DEB_W(2)) dut (
        .pclk  (pclk),
        .reset (reset),
        .bus   (jif)
    );

    typedef struct {
        logic [7:0] p1;
        logic [7:0] p2;
        logic [5:0] js;
        logic [1:0] c;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [1:0] ec;
    } vec_t;

    vec_t vecs [22];
    vec_t exp_q [$];

    logic [7:0] p1_v = 8'hFF;
    logic [7:0] p2_v = 8'hFF;
    logic [5:0] js_v = 6'h3F;
    logic [1:0] c_v  = 2'b11;
    logic       sb_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Harness model: the bus shows garbage in the first settle cycle of every scan.
    assign jif.jjoy     = jif.scan_tick ? 8'h00 : (jif.jselect ? p2_v : p1_v);
    assign jif.joystick = js_v;
    assign jif.jcoin    = c_v;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] p1, input logic [7:0] p2, input logic [5:0] js,
                                input logic [1:0] c, input logic [7:0] e1, input logic [7:0] e2,
                                input logic [1:0] ec);
        vec_t v;
        v.p1 = p1; v.p2 = p2; v.js = js; v.c = c; v.e1 = e1; v.e2 = e2; v.ec = ec;
        return v;
    endfunction

    task automatic apply(input int i);
        p1_v = vecs[i].p1;
        p2_v = vecs[i].p2;
        js_v = vecs[i].js;
        c_v  = vecs[i].c;
        exp_q.push_back(vecs[i]);
    endtask

    task automatic wait_tick();
        for (int c = 0; c < 40; c++) begin
            @(negedge pclk);
            if (jif.scan_tick === 1'b1) return;
        end
        check("wait_tick_timeout", 8'd0, 8'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
            @(negedge pclk);
            #2;
        end
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    endtask

    task automatic check_reset_values();
        check("rst_jselect",   {7'd0, jif.jselect},   8'd0);
        check("rst_joy1",      jif.joy1,              8'hFF);
        check("rst_joy2",      jif.joy2,              8'hFF);
        check("rst_coin",      {6'd0, jif.coin},      8'd3);
        check("rst_scan_tick", {7'd0, jif.scan_tick}, 8'd0);
    endtask

    // Scoreboard monitor: one expectation per completed scan.
    always @(negedge pclk) begin
        if (!reset && sb_en && jif.scan_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_scan_tick", 8'd1, 8'd0);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                check("joy1", jif.joy1, e.e1);
                check("joy2", jif.joy2, e.e2);
                check("coin", {6'd0, jif.coin}, {6'd0, e.ec});
            end
        end
    end

    int   tick_gap = 0;
    int   run_len  = 0;
    logic have_tick = 1'b0;
    logic run_ok    = 1'b0;
    logic prev_js   = 1'b0;

    always @(negedge pclk) begin
        if (reset) begin
            tick_gap  = 0;
            run_len   = 0;
            have_tick = 1'b0;
            run_ok    = 1'b0;
            prev_js   = 1'b0;
        end else begin
            tick_gap++;
            if (jif.jselect === prev_js) begin
                run_len++;
            end else begin
                if (run_ok) check("jselect_phase_len", 8'(run_len), 8'd5);
                run_ok  = 1'b1;
                run_len = 1;
            end
            if (jif.scan_tick === 1'b1) begin
                if (have_tick) check("tick_period", 8'(tick_gap), 8'd10);
                check("tick_after_high", {6'd0, prev_js, jif.jselect}, 8'b10);
                have_tick = 1'b1;
                tick_gap  = 0;
            end
            prev_js = jif.jselect;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //            p1     p2     js     c      joy1   joy2   coin
        vecs[0]  = mk(8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
        vecs[1]  = mk(8'hFE, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
        vecs[2]  = mk(8'hFE, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
        vecs[3]  = mk(8'hFE, 8'hFF, 6'h3F, 2'b11, 8'hFE, 8'hFF, 2'b11);
        vecs[4]  = mk(8'hFE, 8'h7F, 6'h3F, 2'b11, 8'hFE, 8'hFF, 2'b11);
        vecs[5]  = mk(8'hFE, 8'h7F, 6'h3F, 2'b11, 8'hFE, 8'hFF, 2'b11);
        vecs[6]  = mk(8'hFE, 8'hFF, 6'h3F, 2'b11, 8'hFE, 8'hFF, 2'b11);
        vecs[7]  = mk(8'hFE, 8'h7F, 6'h3F, 2'b11, 8'hFE, 8'hFF, 2'b11);
        vecs[8]  = mk(8'hFE, 8'h7F, 6'h3F, 2'b11, 8'hFE, 8'hFF, 2'b11);
        vecs[9]  = mk(8'hFE, 8'h7F, 6'h3F, 2'b11, 8'hFE, 8'h7F, 2'b11);
        vecs[10] = mk(8'hFF, 8'hFF, 6'h3B, 2'b10, 8'hFE, 8'h7F, 2'b11);
        vecs[11] = mk(8'hFF, 8'hFF, 6'h3B, 2'b10, 8'hFE, 8'h7F, 2'b11);
        vecs[12] = mk(8'hFF, 8'hFF, 6'h3B, 2'b10, 8'hFB, 8'hFF, 2'b11);
        vecs[13] = mk(8'hFF, 8'hFF, 6'h3B, 2'b10, 8'hFB, 8'hFF, 2'b10);
        vecs[14] = mk(8'hFF, 8'hFF, 6'h3B, 2'b11, 8'hFB, 8'hFF, 2'b10);
        vecs[15] = mk(8'hFF, 8'hFF, 6'h3B, 2'b10, 8'hFB, 8'hFF, 2'b10);
        vecs[16] = mk(8'hFF, 8'hFF, 6'h3B, 2'b10, 8'hFB, 8'hFF, 2'b10);
        vecs[17] = mk(8'hFF, 8'h7F, 6'h3B, 2'b10, 8'hFB, 8'hFF, 2'b10);
        vecs[18] = mk(8'hFF, 8'h7F, 6'h3B, 2'b10, 8'hFB, 8'hFF, 2'b10);
        vecs[19] = mk(8'hFF, 8'h7F, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
        vecs[20] = mk(8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);
        vecs[21] = mk(8'hFF, 8'hFF, 6'h3F, 2'b11, 8'hFF, 8'hFF, 2'b11);

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_reset_values();
        #1;
        apply(0);
        reset = 1'b0;
        sb_en = 1'b1;

        n = 0;
        while (n < 20) begin
            @(posedge pclk);
            #1;
            n++;
            if (jif.jselect === 1'b1) break;
        end
        check("first_jselect_rise", 8'(n), 8'd5);

        for (int i = 1; i <= 18; i++) begin
            wait_tick();
            #1;
            apply(i);
        end
        drain();

        // P2 now holds a debounce count of 2 toward 7F; reset must discard it.
        sb_en = 1'b0;
        repeat (3) @(posedge pclk);
        #1 reset = 1'b1;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_reset_values();
        #1;
        apply(19);
        reset = 1'b0;
        sb_en = 1'b1;
        for (int i = 20; i <= 21; i++) begin
            wait_tick();
            #1;
            apply(i);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
